// File: rtl/menu_nav_param.sv
// Parametrised menu navigator: cursor browsing over N_ITEMS entries, selection latch,
// optional wrap-around and optional hold timeout on the selected state.
module menu_nav_param #(
  parameter int unsigned N_ITEMS     = 4,
  parameter bit          WRAP        = 1'b0,
  parameter int unsigned HOLD_CYCLES = 0,
  parameter int unsigned IDX_W       = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               act,
  input  logic               AD,
  input  logic               AT,
  input  logic               SEL,
  input  logic               CLC,
  output logic [N_ITEMS-1:0] item_onehot,
  output logic [IDX_W-1:0]   item_idx,
  output logic               act2,
  output logic [N_ITEMS-1:0] sel_onehot,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               done
);

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_ITEMS - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam bit HoldEn = (HOLD_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StBrowse, StSelected} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cursor_q, cursor_d;
  logic [IDX_W-1:0] select_q, select_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [3:0]       btn_q;
  logic [3:0]       btn;
  logic             press_ad, press_at, press_sel, press_clc;

  // Bit order: {AD, AT, SEL, CLC}
  assign btn = {AD, AT, SEL, CLC};
  assign {press_ad, press_at, press_sel, press_clc} = btn & ~btn_q;

  // State, cursor, selection, hold counter and button history registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cursor_q <= '0;
      select_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      btn_q    <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      select_q <= select_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      btn_q    <= btn;
    end
  end

  // Next-state logic: act low dominates, then per-state press handling
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    select_d = select_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (!act) begin
      state_d  = StIdle;
      cursor_d = '0;
      select_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d  = StBrowse;
          cursor_d = '0;
        end
        StBrowse: begin
          if (press_ad) begin
            if (cursor_q >= LastIdx) cursor_d = WRAP ? '0 : LastIdx;
            else                     cursor_d = cursor_q + IDX_W'(1);
          end else if (press_at) begin
            if (cursor_q == '0)          cursor_d = WRAP ? LastIdx : '0;
            else if (cursor_q > LastIdx) cursor_d = LastIdx;
            else                         cursor_d = cursor_q - IDX_W'(1);
          end else if (press_sel) begin
            select_d = cursor_q;
            cnt_d    = '0;
            state_d  = StSelected;
          end else if (press_clc) begin
            cursor_d = '0;
          end
        end
        StSelected: begin
          // CLC and timeout on the same cycle collapse into one exit
          if (press_clc || (HoldEn && (cnt_q == HoldLast))) begin
            state_d  = StBrowse;
            cursor_d = '0;
            cnt_d    = '0;
            done_d   = 1'b1;
          end else if (HoldEn) begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d  = StIdle;
          cursor_d = '0;
          select_d = '0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    item_onehot = '0;
    sel_onehot  = '0;
    if (state_q == StBrowse)   item_onehot = N_ITEMS'(1) << cursor_q;
    if (state_q == StSelected) sel_onehot  = N_ITEMS'(1) << select_q;
    item_idx = cursor_q;
    sel_idx  = select_q;
    act2     = (state_q == StSelected);
    done     = done_q;
  end

endmodule
